// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense arbiter: FSM encoding,
// item slot names and default timing/stock values.
package vend_pkg;

    localparam int ITEM_W = 2;

    localparam logic [ITEM_W-1:0] ITEM_VAFLA   = 2'd0;
    localparam logic [ITEM_W-1:0] ITEM_VODKA   = 2'd1;
    localparam logic [ITEM_W-1:0] ITEM_ARDA    = 2'd2;
    localparam logic [ITEM_W-1:0] ITEM_SLANINA = 2'd3;

    localparam int DEF_INIT_STOCK = 8;
    localparam int DEF_TIMEOUT    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DRIVE,
        ST_WAIT_ACK,
        ST_RELEASE
    } vend_state_e;

endpackage

// File: rtl/vend_dispense_arbiter_if.sv
// Bundle between the arbiter and its environment: front-end request/grant
// handshake, motor handshake, refill strobe and stock/jam status.
interface vend_dispense_arbiter_if
    import vend_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int N_ITEMS = 4
) ();

    logic [N_REQ-1:0]        req;
    logic [N_REQ*ITEM_W-1:0] req_item;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic [N_REQ-1:0]        fail;
    logic                    motor_en;
    logic [ITEM_W-1:0]       motor_item;
    logic                    motor_ack;
    logic                    refill;
    logic [ITEM_W-1:0]       refill_item;
    logic [N_ITEMS-1:0]      item_available;
    logic                    jam;

    // master: front ends plus mechanism; slave: the arbiter itself
    modport master (
        output req, req_item, motor_ack, refill, refill_item,
        input  gnt, done, fail, motor_en, motor_item, item_available, jam
    );

    modport slave (
        input  req, req_item, motor_ack, refill, refill_item,
        output gnt, done, fail, motor_en, motor_item, item_available, jam
    );

endinterface

// File: rtl/vend_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around.
module vend_rr_pick #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             valid
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default first so no path leaves a latch behind.
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!valid && req[idx]) begin
                winner = PTR_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_dispense_arbiter.sv
// Round-robin owner of the shared dispense motor with per-slot stock counters,
// ack timeout and sticky jam. Define VEND_ARB_STATS_EN to add per-slot counters.
module vend_dispense_arbiter
    import vend_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int N_ITEMS    = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = DEF_INIT_STOCK,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    vend_dispense_arbiter_if.slave bus
`ifdef VEND_ARB_STATS_EN
    ,
    output logic [N_ITEMS*8-1:0]   vend_count
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [STOCK_W-1:0] STOCK_MAX = {STOCK_W{1'b1}};

    vend_state_e        state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d, winner_q, winner_d, pick_idx, ptr_inc;
    logic               pick_valid;
    logic [ITEM_W-1:0]  item_q, item_d, motor_item_q, motor_item_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d, done_q, done_d, fail_q, fail_d;
    logic               motor_en_q, motor_en_d, jam_q, jam_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               dispense, timeout_hit, item_empty;
    logic [STOCK_W-1:0] stock [N_ITEMS];
    logic [N_ITEMS-1:0] dispense_hit, refill_hit;

    vend_rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    assign ptr_inc    = (winner_q == PTR_W'(N_REQ - 1)) ? '0 : winner_q + PTR_W'(1);
    assign cnt_inc    = cnt_q + CNT_W'(1);
    // DRIVE plus TIMEOUT-1 WAIT_ACK cycles keeps motor_en high for TIMEOUT cycles
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT - 1));
    assign item_empty  = (stock[item_q] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            winner_q     <= '0;
            item_q       <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            fail_q       <= '0;
            motor_en_q   <= 1'b0;
            motor_item_q <= '0;
            jam_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            winner_q     <= winner_d;
            item_q       <= item_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            motor_en_q   <= motor_en_d;
            motor_item_q <= motor_item_d;
            jam_q        <= jam_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (!jam_q && pick_valid) state_d = ST_CHECK;
            ST_CHECK:    state_d = item_empty ? ST_IDLE : ST_DRIVE;
            ST_DRIVE:    state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: if (bus.motor_ack || timeout_hit) state_d = ST_RELEASE;
            ST_RELEASE:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d        = gnt_q;
        done_d       = '0;
        fail_d       = '0;
        motor_en_d   = motor_en_q;
        motor_item_d = motor_item_q;
        jam_d        = jam_q;
        ptr_d        = ptr_q;
        winner_d     = winner_q;
        item_d       = item_q;
        cnt_d        = cnt_q;
        dispense     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!jam_q && pick_valid) begin
                    winner_d          = pick_idx;
                    item_d            = bus.req_item[int'(pick_idx)*ITEM_W +: ITEM_W];
                    gnt_d             = '0;
                    gnt_d[pick_idx]   = 1'b1;
                end
            end
            ST_CHECK: begin
                if (item_empty) begin
                    fail_d[winner_q] = 1'b1;
                    gnt_d            = '0;
                    ptr_d            = ptr_inc;
                end else begin
                    motor_item_d = item_q;
                    motor_en_d   = 1'b1;
                end
            end
            ST_DRIVE: cnt_d = '0;
            ST_WAIT_ACK: begin
                cnt_d = cnt_inc;
                // an ack on the timeout cycle still counts as a dispense
                if (bus.motor_ack) begin
                    dispense         = 1'b1;
                    done_d[winner_q] = 1'b1;
                    motor_en_d       = 1'b0;
                end else if (timeout_hit) begin
                    motor_en_d       = 1'b0;
                    jam_d            = 1'b1;
                    fail_d[winner_q] = 1'b1;
                end
            end
            ST_RELEASE: begin
                gnt_d = '0;
                ptr_d = ptr_inc;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int k = 0; k < N_ITEMS; k++) begin
            dispense_hit[k] = dispense && (item_q == ITEM_W'(k));
            refill_hit[k]   = bus.refill && (bus.refill_item == ITEM_W'(k));
        end
    end

    // A refill and a dispense on the same slot cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this array is reset on purpose: slots must read INIT_STOCK
            // straight out of reset, unlike a plain storage RAM.
            for (int k = 0; k < N_ITEMS; k++) stock[k] <= STOCK_W'(INIT_STOCK);
        end else begin
            for (int k = 0; k < N_ITEMS; k++) begin
                if (refill_hit[k] && !dispense_hit[k] && stock[k] != STOCK_MAX)
                    stock[k] <= stock[k] + 1'b1;
                else if (dispense_hit[k] && !refill_hit[k] && stock[k] != '0)
                    stock[k] <= stock[k] - 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_ITEMS; k++) bus.item_available[k] = (stock[k] != '0);
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.fail       = fail_q;
    assign bus.motor_en   = motor_en_q;
    assign bus.motor_item = motor_item_q;
    assign bus.jam        = jam_q;

`ifdef VEND_ARB_STATS_EN
    logic [7:0] vend_cnt_q [N_ITEMS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_ITEMS; k++) vend_cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < N_ITEMS; k++)
                if (dispense_hit[k]) vend_cnt_q[k] <= vend_cnt_q[k] + 8'd1;
        end
    end

    always_comb begin
        for (int k = 0; k < N_ITEMS; k++) vend_count[k*8 +: 8] = vend_cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Directed bench for vend_dispense_arbiter: dispense path, round robin, drain,
// refill corner cases, timeout/jam and asynchronous reset.
module tb_vend_dispense_arbiter;

    localparam int N_REQ   = 2;
    localparam int N_ITEMS = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    vend_dispense_arbiter_if #(.N_REQ(N_REQ), .N_ITEMS(N_ITEMS)) bus ();

`ifdef VEND_ARB_STATS_EN
    logic [N_ITEMS*8-1:0] vend_count;
`endif

    vend_dispense_arbiter #(
        .N_REQ(N_REQ), .N_ITEMS(N_ITEMS), .STOCK_W(4), .INIT_STOCK(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef VEND_ARB_STATS_EN
        ,
        .vend_count (vend_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns the number of negedges waited for gnt[r], or -1 if it never came.
    task automatic wait_gnt(input int r, output int cyc);
        cyc = -1;
        for (int i = 0; i <= 40; i++) begin
            if (bus.gnt[r]) begin
                cyc = i;
                break;
            end
            tick();
        end
    endtask

    // Serves an already-raised request of requester r; ack arrives ack_after
    // cycles after motor_en is first seen.
    task automatic serve(input int r, input logic [1:0] item, input int ack_after,
                         input bit refill_same, input string tag);
        int cyc;
        wait_gnt(r, cyc);
        check({tag, " gnt"}, 32'(bus.gnt), 32'(1) << r);
        tick();
        check({tag, " motor_en"}, 32'(bus.motor_en), 32'd1);
        check({tag, " motor_item"}, 32'(bus.motor_item), 32'(item));
        repeat (ack_after - 1) tick();
        bus.motor_ack = 1'b1;
        if (refill_same) begin
            bus.refill      = 1'b1;
            bus.refill_item = item;
        end
        tick();
        bus.motor_ack = 1'b0;
        bus.refill    = 1'b0;
        check({tag, " done"}, 32'(bus.done), 32'(1) << r);
        check({tag, " motor_off"}, 32'(bus.motor_en), 32'd0);
        bus.req[r] = 1'b0;
        tick();
        check({tag, " release"}, 32'({bus.gnt, bus.done}), 32'd0);
    endtask

    task automatic raise(input int r, input logic [1:0] item);
        bus.req_item[2*r +: 2] = item;
        bus.req[r]             = 1'b1;
    endtask

    task automatic refill_pulse(input logic [1:0] item);
        bus.refill      = 1'b1;
        bus.refill_item = item;
        tick();
        bus.refill      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int cyc;
        int cnt;
        bit en_seen;

        bus.req = '0;
        bus.req_item = '0;
        bus.motor_ack = 1'b0;
        bus.refill = 1'b0;
        bus.refill_item = '0;

        // Reset state
        #12;
        check("rst gnt", 32'(bus.gnt), 32'd0);
        check("rst done_fail", 32'({bus.done, bus.fail}), 32'd0);
        check("rst motor", 32'({bus.motor_en, bus.motor_item}), 32'd0);
        check("rst jam", 32'(bus.jam), 32'd0);
        check("rst avail", 32'(bus.item_available), 32'hf);
        for (int k = 0; k < N_ITEMS; k++) check("rst stock", 32'(dut.stock[k]), 32'd8);
        tick();
        rst = 1'b1;
        tick();

        // Single dispense of slot 2, ack 3 cycles after motor_en
        raise(0, 2'd2);
        wait_gnt(0, cyc);
        check("t1 gnt latency", 32'(cyc), 32'd1);
        serve(0, 2'd2, 3, 1'b0, "t1");
        check("t1 stock2", 32'(dut.stock[2]), 32'd7);
        check("t1 avail", 32'(bus.item_available), 32'hf);

        // Simultaneous requests, round robin from requester 0
        do_reset();
        check("t2 stock2 reset", 32'(dut.stock[2]), 32'd8);
        raise(0, 2'd0);
        raise(1, 2'd0);
        tick();
        check("t2 first gnt", 32'(bus.gnt), 32'b01);
        serve(0, 2'd0, 2, 1'b0, "t2 r0");
        serve(1, 2'd0, 2, 1'b0, "t2 r1");
        check("t2 stock0", 32'(dut.stock[0]), 32'd6);
        raise(0, 2'd0);
        raise(1, 2'd0);
        tick();
        check("t2 next round gnt", 32'(bus.gnt), 32'b01);
        serve(0, 2'd0, 2, 1'b0, "t2b r0");
        serve(1, 2'd0, 2, 1'b0, "t2b r1");
        check("t2 stock0 again", 32'(dut.stock[0]), 32'd4);

        // Drain slot 3, then the ninth request fails in CHECK
        for (int n = 0; n < 8; n++) begin
            raise(0, 2'd3);
            serve(0, 2'd3, 2, 1'b0, "drain");
        end
        check("t3 stock3", 32'(dut.stock[3]), 32'd0);
        check("t3 avail", 32'(bus.item_available), 32'b0111);
        raise(0, 2'd3);
        tick();
        check("t3 gnt", 32'(bus.gnt), 32'b01);
        en_seen = bus.motor_en;
        tick();
        en_seen |= bus.motor_en;
        check("t3 fail", 32'(bus.fail), 32'b01);
        check("t3 gnt cleared", 32'(bus.gnt), 32'd0);
        bus.req[0] = 1'b0;
        tick();
        en_seen |= bus.motor_en;
        check("t3 fail single", 32'(bus.fail), 32'd0);
        check("t3 motor never", 32'(en_seen), 32'd0);

        // Slot 1: 8 -> 5, coincident refill+ack holds 5, then saturate at 15
        for (int n = 0; n < 3; n++) begin
            raise(0, 2'd1);
            serve(0, 2'd1, 2, 1'b0, "slot1");
        end
        check("t4 stock1 five", 32'(dut.stock[1]), 32'd5);
        raise(0, 2'd1);
        serve(0, 2'd1, 2, 1'b1, "refill+ack");
        check("t4 stock1 hold", 32'(dut.stock[1]), 32'd5);
        repeat (10) refill_pulse(2'd1);
        check("t4 stock1 full", 32'(dut.stock[1]), 32'd15);
        refill_pulse(2'd1);
        check("t4 stock1 sat", 32'(dut.stock[1]), 32'd15);

        // Asynchronous reset in the middle of WAIT_ACK
        raise(1, 2'd0);
        wait_gnt(1, cyc);
        tick();
        tick();
        tick();
        check("t5 motor before", 32'(bus.motor_en), 32'd1);
        rst = 1'b0;
        #1;
        check("t5 motor async", 32'(bus.motor_en), 32'd0);
        check("t5 gnt async", 32'(bus.gnt), 32'd0);
        check("t5 jam async", 32'(bus.jam), 32'd0);
        for (int k = 0; k < N_ITEMS; k++) check("t5 stock reset", 32'(dut.stock[k]), 32'd8);
        bus.req = '0;
        tick();
        rst = 1'b1;
        tick();

        // No ack: motor_en high TIMEOUT cycles, then fail and sticky jam
        raise(0, 2'd2);
        wait_gnt(0, cyc);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!bus.motor_en) break;
            cnt++;
        end
        check("t6 motor cycles", 32'(cnt), 32'(TIMEOUT));
        check("t6 fail", 32'(bus.fail), 32'b01);
        check("t6 jam", 32'(bus.jam), 32'd1);
        bus.req[0] = 1'b0;
        tick();
        raise(1, 2'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.gnt != '0) cnt++;
        end
        check("t6 no gnt jammed", 32'(cnt), 32'd0);
        check("t6 jam sticky", 32'(bus.jam), 32'd1);
        refill_pulse(2'd2);
        check("t6 refill jammed", 32'(dut.stock[2]), 32'd9);
        rst = 1'b0;
        #1;
        check("t6 jam cleared", 32'(bus.jam), 32'd0);
        tick();
        rst = 1'b1;
        serve(1, 2'd0, 2, 1'b0, "post reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
